// File: rtl/div_pkg.sv
// Shared definitions for the restoring 16/8 divider program: FSM states,
// data-memory addresses and the iteration count.
package div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_STORE,
        ST_DONE
    } div_state_t;

    localparam logic [7:0] ADDR_DVD_HI = 8'd4;
    localparam logic [7:0] ADDR_DVD_LO = 8'd5;
    localparam logic [7:0] ADDR_DVSR   = 8'd6;
    localparam logic [7:0] ADDR_Q_HI   = 8'd8;
    localparam logic [7:0] ADDR_Q_LO   = 8'd9;
    localparam logic [7:0] ADDR_REM    = 8'd10;
    localparam logic [7:0] ADDR_DZ     = 8'd11;

    localparam int N_ITER = 16;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step (
    input  logic [8:0] i_r,
    input  logic       i_qMsb,
    input  logic [7:0] i_d,
    output logic [8:0] o_r,
    output logic       o_qBit
);

    logic [9:0] w_trial;
    logic [9:0] w_diff;

    // The top remainder bit is always zero while r < d, so the wide trial value
    // only matters for the divide-by-zero run, whose results get overridden.
    assign w_trial = {i_r, i_qMsb};
    assign w_diff  = w_trial - {2'b00, i_d};
    assign o_qBit  = (w_trial >= {2'b00, i_d});
    assign o_r     = o_qBit ? w_diff[8:0] : w_trial[8:0];

endmodule

// File: rtl/program_2_divide.sv
// Self-contained divide program: reads a 16-bit dividend and 8-bit divisor from
// its data memory, runs 16 restoring steps and writes quotient/remainder/flag back.
module program_2_divide
    import div_pkg::*;
(
    input  logic clk,
    input  logic init,
    output logic done
);

    logic [7:0]  data_ram [256];

    div_state_t  r_state;
    div_state_t  w_stateNext;
    logic [15:0] r_q;
    logic [15:0] w_qNext;
    logic [8:0]  r_r;
    logic [8:0]  w_rNext;
    logic [7:0]  r_d;
    logic [7:0]  w_dNext;
    logic [3:0]  r_count;
    logic [3:0]  w_countNext;
    logic        r_done;
    logic        w_doneNext;
    logic [8:0]  w_stepR;
    logic        w_stepBit;

    div_step u_step (
        .i_r    (r_r),
        .i_qMsb (r_q[15]),
        .i_d    (r_d),
        .o_r    (w_stepR),
        .o_qBit (w_stepBit)
    );

    // IDLE performs the operand load itself so that the first free edge after
    // init already captures the operands; LOAD is an alias of the same action.
    always_comb begin
        w_stateNext = r_state;
        w_qNext     = r_q;
        w_rNext     = r_r;
        w_dNext     = r_d;
        w_countNext = r_count;
        w_doneNext  = r_done;
        case (r_state)
            ST_IDLE, ST_LOAD: begin
                w_qNext     = {data_ram[ADDR_DVD_HI], data_ram[ADDR_DVD_LO]};
                w_rNext     = 9'd0;
                w_dNext     = data_ram[ADDR_DVSR];
                w_countNext = 4'd0;
                w_stateNext = ST_ITER;
            end
            ST_ITER: begin
                w_qNext     = {r_q[14:0], w_stepBit};
                w_rNext     = w_stepR;
                w_countNext = r_count + 4'd1;
                if (r_count == 4'(N_ITER - 1)) begin
                    w_stateNext = ST_STORE;
                end
            end
            ST_STORE: begin
                w_stateNext = ST_DONE;
            end
            ST_DONE: begin
                w_doneNext = 1'b1;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            r_state <= ST_IDLE;
            r_q     <= 16'd0;
            r_r     <= 9'd0;
            r_d     <= 8'd0;
            r_count <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_q     <= w_qNext;
            r_r     <= w_rNext;
            r_d     <= w_dNext;
            r_count <= w_countNext;
            r_done  <= w_doneNext;
        end
    end

    // Only the result slots are written; operand locations belong to the host.
    always_ff @(posedge clk) begin
        if (init) begin
            data_ram[ADDR_Q_HI] <= 8'h00;
            data_ram[ADDR_Q_LO] <= 8'h00;
            data_ram[ADDR_REM]  <= 8'h00;
            data_ram[ADDR_DZ]   <= 8'h00;
        end else if (r_state == ST_STORE) begin
            if (r_d == 8'd0) begin
                data_ram[ADDR_Q_HI] <= 8'hFF;
                data_ram[ADDR_Q_LO] <= 8'hFF;
                data_ram[ADDR_REM]  <= 8'hFF;
                data_ram[ADDR_DZ]   <= 8'h01;
            end else begin
                data_ram[ADDR_Q_HI] <= r_q[15:8];
                data_ram[ADDR_Q_LO] <= r_q[7:0];
                data_ram[ADDR_REM]  <= r_r[7:0];
                data_ram[ADDR_DZ]   <= 8'h00;
            end
        end
    end

    assign done = r_done;

endmodule

// File: doc/program_2_divide.md
# program_2_divide

Self-contained hardware program that divides an unsigned 16-bit dividend by an unsigned 8-bit divisor using restoring shift-subtract division, one quotient bit per cycle. It is the inverse companion of the product program: it consumes a 16-bit value in the same high/low byte layout (memory locations 4/5) and writes quotient, remainder and an error flag back into its internal 256x8 data memory. The testbench loads operands into the memory hierarchically and polls `done`.

## Interface
- Parameters: none (widths fixed: dividend 16 bits, divisor 8 bits, quotient 16 bits, remainder 8 bits).
- `clk`  input  1  single clock; all state updates on rising edge.
- `init`  input  1  synchronous, active-high reset/start; one clock, reset is synchronous and active-high.
- `done`  output  1  completion flag; reset value 0; held high until next `init`.
- Internal `data_ram[256]` (8-bit), written by the testbench by hierarchical reference: mem[4] dividend high, mem[5] dividend low, mem[6] divisor.
- Results: mem[8] quotient high, mem[9] quotient low, mem[10] remainder, mem[11] divide-by-zero flag (0x01/0x00).

## Operation
- States: IDLE, LOAD, ITER, STORE, DONE.
- `init` high (any cycle, any state): state <= IDLE, `done` <= 0, iteration counter <= 0, mem[8..11] <= 0; mem[0..7] untouched.
- IDLE: first edge with `init` low executes LOAD.
- LOAD: q <= {mem[4],mem[5]}; r <= 9'd0; d <= mem[6]; counter <= 0; -> ITER.
- ITER (exactly 16 cycles): t = {r[7:0], q[15]}; q <= {q[14:0], t >= d}; r <= (t >= d) ? t - d : t; counter++; after 16th iteration -> STORE.
- r is 9 bits; invariant r < d after each step, so remainder fits 8 bits.
- STORE: if d == 0: mem[8],mem[9] <= 0xFF, mem[10] <= 0xFF, mem[11] <= 0x01 (iterations still run, results overridden). Else mem[8] <= q[15:8], mem[9] <= q[7:0], mem[10] <= r[7:0], mem[11] <= 0x00. -> DONE.
- DONE: `done` <= 1; stays in DONE indefinitely, memory stable, until `init`.
- Operands are sampled only in LOAD; testbench writes to mem[4..6] after LOAD do not affect the running division.

## Timing
- Count rising edges after the cycle in which `init` is last sampled high: edge 1 LOAD, edges 2-17 ITER, edge 18 STORE, edge 19 `done` rises.
- Fixed latency 19 cycles, independent of operand values (including divide-by-zero).
- Results in mem[8..11] valid from edge 18; guaranteed valid when `done` is seen high.
- `init` reasserted mid-operation: aborts on that edge, no partial results retained; restart runs the full 19 cycles from the next `init` deassertion.

## Structure
- Package `div_pkg`: state enum `div_state_t`; address constants `ADDR_DVD_HI=4`, `ADDR_DVD_LO=5`, `ADDR_DVSR=6`, `ADDR_Q_HI=8`, `ADDR_Q_LO=9`, `ADDR_REM=10`, `ADDR_DZ=11`; `N_ITER=16`.
- Sub-module `div_step`: combinational single restoring step (inputs r[8:0], q msb, d[7:0]; outputs next r, quotient bit). Top holds FSM, counter, registers, memory.

## Test plan
- 6000/7: mem[4]=0x17, mem[5]=0x70, mem[6]=0x07 -> mem[8]=0x03, mem[9]=0x59 (857), mem[10]=0x01, mem[11]=0x00, `done` at edge 19.
- Divide by zero: 0x1234/0 -> mem[8]=0xFF, mem[9]=0xFF, mem[10]=0xFF, mem[11]=0x01, `done` at edge 19.
- Dividend < divisor: 5/200 -> quotient 0x0000, remainder 0x05; 0xFFFF/1 -> quotient 0xFFFF, remainder 0x00.
- 1000/255 -> quotient 0x0003, remainder 0xEB (235); 0xFFFF/0xFF -> quotient 0x0101, remainder 0x00.
- Reset mid-op: start 6000/7, assert `init` at edge 10, load 100/9, release -> mem[8..11] = 0x00,0x0B,0x01,0x00; `done` low until edge 19 after release.
- Round trip: product 0x2A30 (A=12,B=15,C=60) in mem[4..5], divisor 60 -> quotient 180 (0x00B4), remainder 0; `done` stays high for 20 further cycles with memory unchanged.
